// File: rtl/fetch_32.sv
// Fetch stage: PC, one-at-a-time imem req/ack, instruction buffer toward decode; word visible 1 cycle after ack.
// Backpressure: stall_in only blocks pops; issue stops when buffered + outstanding words would exceed BUF_DEPTH.

module fetch_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     wr_vld,
   input  logic [W-1:0]             wr_dat,
   output logic                     rd_vld,
   input  logic                     rd_rdy,
   output logic [W-1:0]             rd_dat,
   output logic [$clog2(DEPTH):0]   cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign rd_vld = (cnt != '0);
   assign rd_dat = mem[rd_ptr];
   assign do_wr  = wr_vld && (cnt < CW'(DEPTH));
   assign do_rd  = rd_vld && rd_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         // flush wins over any same-cycle write or read
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

module fetch_32 #(
   parameter logic [31:0] PC_RESET  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk_in,
   input  logic        reset_in,
   output logic        imem_req_out,
   output logic [31:0] imem_addr_out,
   input  logic        imem_ack_in,
   input  logic [31:0] imem_data_in,
   input  logic        redirect_in,
   input  logic [31:0] redirect_pc_in,
   input  logic        stall_in,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out,
   output logic        inst_valid_out,
   output logic        misalign_flg_out
);
   localparam int CW = $clog2(BUF_DEPTH) + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ibuf_ent_t;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2,
      HALT    = 2'd3
   } state_t;

   state_t        state;
   logic [31:0]   pc;
   logic          halt_pend;
   logic [CW-1:0] buf_cnt;
   ibuf_ent_t     push_dat;
   ibuf_ent_t     head_dat;
   logic          push_vld;
   logic          pop_rdy;
   logic          misaligned;
   logic          can_issue;
   logic          ack_pend;

   assign misaligned    = (redirect_pc_in[1:0] != 2'b00);
   assign can_issue     = (buf_cnt < CW'(BUF_DEPTH));
   assign push_vld      = (state == WAIT) && imem_ack_in && !redirect_in;
   assign push_dat.pc   = pc;
   assign push_dat.inst = imem_data_in;
   assign pop_rdy       = !stall_in;
   assign inst_out      = head_dat.inst;
   assign pc_out        = head_dat.pc;

   // A memory request is still in flight after this cycle and its ack must be swallowed.
   assign ack_pend = ((state == WAIT) || (state == DISCARD) || ((state == HALT) && halt_pend))
                     && !imem_ack_in;

   fetch_fifo #(
      .W     ($bits(ibuf_ent_t)),
      .DEPTH (BUF_DEPTH)
   ) u_ibuf (
      .clk    (clk_in),
      .rst    (reset_in),
      .flush  (redirect_in),
      .wr_vld (push_vld),
      .wr_dat (push_dat),
      .rd_vld (inst_valid_out),
      .rd_rdy (pop_rdy),
      .rd_dat (head_dat),
      .cnt    (buf_cnt)
   );

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state            <= FETCH;
         pc               <= PC_RESET;
         halt_pend        <= 1'b0;
         imem_req_out     <= 1'b0;
         imem_addr_out    <= '0;
         misalign_flg_out <= 1'b0;
      end else if (redirect_in) begin
         pc           <= redirect_pc_in;
         imem_req_out <= 1'b0;
         if (misaligned) begin
            state            <= HALT;
            misalign_flg_out <= 1'b1;
            halt_pend        <= ack_pend;
         end else begin
            state            <= ack_pend ? DISCARD : FETCH;
            misalign_flg_out <= 1'b0;
            halt_pend        <= 1'b0;
         end
      end else begin
         case (state)
            FETCH: begin
               if (can_issue) begin
                  imem_req_out  <= 1'b1;
                  imem_addr_out <= pc;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (imem_ack_in) begin
                  imem_req_out <= 1'b0;
                  pc           <= pc + 32'd4;
                  state        <= FETCH;
               end
            end
            DISCARD: begin
               if (imem_ack_in) begin
                  state <= FETCH;
               end
            end
            HALT: begin
               if (imem_ack_in) begin
                  halt_pend <= 1'b0;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_32.sv
// Bench for fetch_32: scoreboarded memory model plus a per-cycle vector table for the halt/redirect corner.
module tb_fetch_32;
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        req, ack = 1'b0, redirect = 1'b0, stall = 1'b0, valid, flag;
   logic [31:0] addr, data = '0, rpc = '0, inst, pc_o;

   logic        req_b, ack_b = 1'b0, valid_b, flag_b;
   logic        redir_b = 1'b0, stall_b = 1'b0;
   logic [31:0] addr_b, data_b = '0, rpc_b = '0, inst_b, pc_b;

   fetch_32 u_dut (
      .clk_in(clk), .reset_in(rst), .imem_req_out(req), .imem_addr_out(addr),
      .imem_ack_in(ack), .imem_data_in(data), .redirect_in(redirect), .redirect_pc_in(rpc),
      .stall_in(stall), .inst_out(inst), .pc_out(pc_o), .inst_valid_out(valid),
      .misalign_flg_out(flag));

   fetch_32 #(.PC_RESET(32'hFFFF_FFF8)) u_dut_wrap (
      .clk_in(clk), .reset_in(rst), .imem_req_out(req_b), .imem_addr_out(addr_b),
      .imem_ack_in(ack_b), .imem_data_in(data_b), .redirect_in(redir_b), .redirect_pc_in(rpc_b),
      .stall_in(stall_b), .inst_out(inst_b), .pc_out(pc_b), .inst_valid_out(valid_b),
      .misalign_flg_out(flag_b));

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } sb_t;

   typedef struct {
      bit          redir;
      logic [31:0] rpc;
      bit          stall;
      bit          e_req;
      bit          chk_addr;
      logic [31:0] e_addr;
      bit          e_flag;
      bit          e_valid;
   } vec_t;

   sb_t         exp_q[$];
   logic [31:0] req_log[$];
   logic [31:0] b_log[$];
   int          n_pass = 0, n_total = 0, n_pops = 0, cyc = 0, lat = 1, mem_age = 0;
   bit          mem_pend = 0, mem_kill = 0;
   logic [31:0] mem_addr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Inputs for this cycle are already driven; score them, clock, then update the memory models.
   task automatic cycle();
      sb_t e;
      if (rst || redirect) begin
         exp_q.delete();
         if (mem_pend) mem_kill = 1;
      end else begin
         if (valid && !stall) begin
            n_pops++;
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL sb_unexpected: popped pc %h inst %h, none expected", pc_o, inst);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", pc_o, e.pc);
               check("sb_inst", inst, e.inst);
            end
         end
         if (ack && !mem_kill) begin
            e.pc   = mem_addr;
            e.inst = data;
            exp_q.push_back(e);
         end
      end
      @(posedge clk); #1; cyc++;
      if (ack) begin
         ack = 0; mem_kill = 0;
      end else if (mem_pend) begin
         mem_age++;
         if (mem_age >= lat) begin ack = 1; data = mem_word(mem_addr); mem_pend = 0; end
      end else if (req) begin
         mem_pend = 1; mem_addr = addr; mem_age = 0; mem_kill = 0;
         req_log.push_back(addr);
      end
      if (ack_b) ack_b = 0;
      else if (req_b) begin
         ack_b = 1; data_b = mem_word(addr_b);
         if (b_log.size() < 4) b_log.push_back(addr_b);
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1;
      repeat (n) cycle();
      req_log.delete();
   endtask

   vec_t vt[9];
   int   t_req, t_val;
   bit   found, b_checked;

   initial begin
      vt[0] = '{1, 32'h102, 1, 0, 0, 32'h0,   1, 0};
      vt[1] = '{0, 32'h0,   0, 0, 0, 32'h0,   1, 0};
      vt[2] = '{0, 32'h0,   0, 0, 0, 32'h0,   1, 0};
      vt[3] = '{1, 32'h305, 0, 0, 0, 32'h0,   1, 0};
      vt[4] = '{1, 32'h200, 0, 0, 0, 32'h0,   0, 0};
      vt[5] = '{0, 32'h0,   0, 1, 1, 32'h200, 0, 0};
      vt[6] = '{0, 32'h0,   0, 1, 1, 32'h200, 0, 0};
      vt[7] = '{0, 32'h0,   0, 0, 0, 32'h0,   0, 1};
      vt[8] = '{0, 32'h0,   0, 1, 1, 32'h204, 0, 0};

      // reset state
      do_reset(4);
      check("rst_req", req, 0);
      check("rst_addr", addr, 0);
      check("rst_inst", inst, 0);
      check("rst_pc", pc_o, 0);
      check("rst_valid", valid, 0);
      check("rst_flag", flag, 0);

      // 1: streaming fetch, plus wrap instance running alongside
      rst = 0; t_req = -1; t_val = -1; b_checked = 0;
      repeat (24) begin
         cycle();
         if (req && t_req < 0) t_req = cyc;
         if (valid && t_val < 0) t_val = cyc;
         if (valid_b && !b_checked) begin
            check("wrap_inst", inst_b, mem_word(pc_b));
            b_checked = 1;
         end
      end
      check("t1_valid_delay", t_val - t_req, 2);
      check("t1_nreq", req_log.size() >= 4, 1);
      if (req_log.size() >= 4)
         for (int i = 0; i < 4; i++) check($sformatf("t1_addr[%0d]", i), req_log[i], 32'(4 * i));
      check("t1_pops", n_pops >= 4, 1);
      check("wrap_nreq", b_log.size() >= 3, 1);
      if (b_log.size() >= 3) begin
         check("wrap_addr0", b_log[0], 32'hFFFF_FFF8);
         check("wrap_addr1", b_log[1], 32'hFFFF_FFFC);
         check("wrap_addr2", b_log[2], 32'h0000_0000);
      end
      check("wrap_flag", flag_b, 0);

      // 2: stall fills the buffer, then drains in order
      stall = 1;
      do_reset(4);
      rst = 0;
      repeat (16) cycle();
      check("t2_nreq", req_log.size(), 2);
      if (req_log.size() == 2) begin
         check("t2_addr0", req_log[0], 32'h0);
         check("t2_addr1", req_log[1], 32'h4);
      end
      check("t2_req_idle", req, 0);
      check("t2_valid", valid, 1);
      check("t2_head_pc", pc_o, 32'h0);
      stall = 0;
      repeat (12) cycle();
      check("t2_resume", req_log.size() >= 3, 1);
      if (req_log.size() >= 3) check("t2_addr2", req_log[2], 32'h8);

      // 3: redirect while the fetch of 0x10 is outstanding
      do_reset(4);
      lat = 3; rst = 0; found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         cycle();
         if (mem_pend && mem_age == 0 && mem_addr == 32'h10) found = 1;
      end
      check("t3_reach_0x10", found, 1);
      redirect = 1; rpc = 32'h100;
      cycle();
      redirect = 0;
      check("t3_flush_valid", valid, 0);
      check("t3_req_dropped", req, 0);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle();
         if (valid) begin check("t3_first_pc", pc_o, 32'h100); found = 1; end
      end
      check("t3_valid_seen", found, 1);
      found = 0;
      for (int i = 0; i + 1 < req_log.size(); i++)
         if (req_log[i] == 32'h10) begin check("t3_next_addr", req_log[i+1], 32'h100); found = 1; end
      check("t3_addr_logged", found, 1);

      // 4: misaligned redirect halts, aligned redirect restarts
      stall = 1;
      do_reset(4);
      lat = 1; rst = 0;
      repeat (12) cycle();
      for (int i = 0; i < 9; i++) begin
         redirect = vt[i].redir; rpc = vt[i].rpc; stall = vt[i].stall;
         cycle();
         check($sformatf("t4_req[%0d]", i), req, vt[i].e_req);
         check($sformatf("t4_flag[%0d]", i), flag, vt[i].e_flag);
         check($sformatf("t4_valid[%0d]", i), valid, vt[i].e_valid);
         if (vt[i].chk_addr) check($sformatf("t4_addr[%0d]", i), addr, vt[i].e_addr);
      end
      redirect = 0; stall = 0;

      // 6: reset with a request in flight, stray ack right after
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         if (mem_pend && mem_age == 0) found = 1;
      end
      check("t6_req_inflight", found, 1);
      rst = 1;
      cycle();
      check("t6_rst_req", req, 0);
      check("t6_rst_valid", valid, 0);
      check("t6_stray_ack", ack, 1);
      rst = 0;
      cycle();
      check("t6_req", req, 1);
      check("t6_addr", addr, 32'h0);
      check("t6_valid", valid, 0);
      cycle();
      check("t6_no_stray_push", valid, 0);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         cycle();
         if (valid) begin check("t6_first_pc", pc_o, 32'h0); found = 1; end
      end
      check("t6_valid_seen", found, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
